instr_prefetch_unit: RTL and testbench

INSTR_PREFETCH_UNIT -- requirements
Module: instr_prefetch_unit

---
 rtl/instr_prefetch_unit.sv | 177 +++++++++++++++++
 tb/tb_instr_prefetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: single-outstanding instruction prefetcher feeding a
// DEPTH-entry FIFO of {pc, instr}. Redirects flush the FIFO and restart the
// fetch stream; a redirect that races an unacked request parks in DISCARD
// until that ack arrives so the stale word is dropped.
// Optional build macro PREFETCH_STATS_EN adds a fetch_count output counting
// every instruction word actually pushed into the FIFO.
module instr_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DISCARD} state_e;

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [DEPTH-1:0][31:0] data_q, data_d, pc_q, pc_d;

    logic          ack, push, pop, flush;
    logic [31:0]   redir_pc;
    logic [CW-1:0] count_nxt;

    // An ack only counts while our request is actually on the bus; this also
    // swallows acks for requests abandoned by reset.
    assign ack       = mem_ack & req_q;
    assign redir_pc  = {redirect_pc[31:2], 2'b00};
    assign pop       = instr_valid & instr_ready & ~redirect_valid;
    assign push      = (state_q == S_FETCH) & ack & ~redirect_valid;
    assign count_nxt = count_q + CW'(push) - CW'(pop);

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = data_q[rd_ptr_q];
    assign instr_pc    = pc_q[rd_ptr_q];

    // Fetch control: decide next request, fetch_pc and state each cycle.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        flush      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_pc;
                    if (req_q && !mem_ack) begin
                        state_d = S_DISCARD;
                    end else begin
                        req_d  = 1'b1;
                        addr_d = redir_pc;
                    end
                end else if (ack || !req_q) begin
                    if (ack) fetch_pc_d = fetch_pc_q + 32'd4;
                    // Next request only if it still fits once outstanding.
                    if (count_nxt < CW'(DEPTH)) begin
                        req_d  = 1'b1;
                        addr_d = fetch_pc_d;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_pc;
                    req_d      = 1'b1;
                    addr_d     = redir_pc;
                    state_d    = S_FETCH;
                end else if (count_nxt < CW'(DEPTH)) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                // Request stays on the bus unchanged; only the target moves.
                if (redirect_valid) begin
                    flush      = 1'b1;
                    fetch_pc_d = redir_pc;
                end
                if (ack) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_d;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // FIFO bookkeeping: push at write pointer, pop at read pointer, flush all.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_nxt;
        data_d   = data_q;
        pc_d     = pc_q;
        if (push) begin
            data_d[wr_ptr_q] = mem_rdata;
            pc_d[wr_ptr_q]   = fetch_pc_q;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_q     <= '0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;

    assign fetch_count_d = fetch_count_q + 32'(push);
    assign fetch_count   = fetch_count_q;

    // Count accepted pushes only; dropped words never reach push.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) fetch_count_q <= '0;
        else      fetch_count_q <= fetch_count_d;
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the fetch stream.
module tb_instr_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic        clock, rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr, instr_pc;
    logic        instr_ready;

    int checks   = 0;
    int failures = 0;

    instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: one optional outstanding request plus a queue of
    // delivered {pc, word} pairs.
    bit          m_out, m_disc;
    logic [31:0] m_raddr, m_npc;
    logic [63:0] m_q[$];

    task automatic model_reset();
        m_out = 0; m_disc = 0; m_raddr = RESET_PC; m_npc = RESET_PC;
        m_q.delete();
    endtask

    task automatic model_step(input bit rv, input logic [31:0] rpc, input bit ack_in,
                              input bit rdy, input logic [31:0] rdata);
        bit ack;
        logic [31:0] t;
        ack = ack_in && m_out;
        t   = {rpc[31:2], 2'b00};
        if (rv) begin
            m_q.delete();
            if (m_out && !ack) begin m_disc = 1; m_npc = t; end
            else begin m_disc = 0; m_out = 1; m_raddr = t; m_npc = t; end
        end else if (m_disc) begin
            if (ack) begin m_disc = 0; m_raddr = m_npc; end
        end else begin
            if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
            if (ack) begin m_q.push_back({m_raddr, rdata}); m_npc = m_raddr + 32'd4; end
            if ((!m_out || ack) && m_q.size() < DEPTH) begin m_out = 1; m_raddr = m_npc; end
            else if (ack) m_out = 0;
        end
    endtask

    // Apply one cycle of inputs, advance the model, return at the next negedge.
    task automatic tick(input bit rv, input logic [31:0] rpc, input bit ack, input bit rdy);
        logic [31:0] d;
        d = $urandom;
        redirect_valid = rv; redirect_pc = rpc; mem_ack = ack;
        mem_rdata = d; instr_ready = rdy;
        model_step(rv, rpc, ack, rdy, d);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 0; redirect_pc = '0; mem_ack = 0; mem_rdata = '0; instr_ready = 0;
        model_reset();
        repeat (2) @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        checks++; if (mem_addr !== RESET_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", mem_addr, RESET_PC); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr); end
        checks++; if (instr_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
        @(negedge clock);
        rst = 1'b1;
    endtask

    // Zero-wait memory, core always ready: one word per cycle.
    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick(0, '0, 1, 1);
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'(4 * (i - 1))) begin
                failures++; $display("FAIL stream_addr cyc=%0d got=%b/%h exp=1/%h", i, mem_req, mem_addr, 4 * (i - 1)); end
            if (i >= 2) begin
                checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * (i - 2))) begin
                    failures++; $display("FAIL stream_pc cyc=%0d got=%b/%h exp=1/%h", i, instr_valid, instr_pc, 4 * (i - 2)); end
                checks++; if ({instr_pc, instr} !== m_q[0]) begin
                    failures++; $display("FAIL stream_word cyc=%0d got=%h exp=%h", i, instr, m_q[0][31:0]); end
            end
        end
    endtask

    // Core stalled: FIFO fills to DEPTH, then one pop buys exactly one fetch.
    task automatic test_hold();
        int pushes, reqs;
        logic [31:0] seen_addr;
        do_reset();
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req === 1'b1) pushes++;
            tick(0, '0, mem_req === 1'b1, 0);
        end
        checks++; if (pushes != 4) begin failures++; $display("FAIL hold_pushes got=%0d exp=4", pushes); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL hold_req got=%b exp=0", mem_req); end
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd0) begin
            failures++; $display("FAIL hold_head got=%b/%h exp=1/0", instr_valid, instr_pc); end
        tick(0, '0, 0, 1);
        reqs = 0; seen_addr = '1;
        for (int i = 0; i < 6; i++) begin
            if (mem_req === 1'b1) begin reqs++; seen_addr = mem_addr; end
            tick(0, '0, mem_req === 1'b1, 0);
        end
        checks++; if (reqs != 1) begin failures++; $display("FAIL hold_refetch_count got=%0d exp=1", reqs); end
        checks++; if (seen_addr !== 32'h10) begin failures++; $display("FAIL hold_refetch_addr got=%h exp=10", seen_addr); end
        checks++; if (instr_pc !== 32'd4) begin failures++; $display("FAIL hold_after_pop got=%h exp=4", instr_pc); end
    endtask

    // Redirect while 0x8 is outstanding and unacked: word dropped, 0x100 next.
    task automatic test_redirect_discard();
        bit found;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req === 1'b1 && mem_addr === 32'h8) found = 1;
            else tick(0, '0, 1, 1);
        end
        checks++; if (!found) begin failures++; $display("FAIL disc_reach got=timeout exp=addr 8"); end
        tick(1, 32'h103, 0, 1);
        for (int i = 0; i < 2; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
                failures++; $display("FAIL disc_stable got=%b/%h exp=1/8", mem_req, mem_addr); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL disc_flush got=%b exp=0", instr_valid); end
            tick(0, '0, 0, 1);
        end
        tick(0, '0, 1, 1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            failures++; $display("FAIL disc_next_addr got=%b/%h exp=1/100", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL disc_dropped got=%b exp=0", instr_valid); end
        tick(0, '0, 1, 1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            failures++; $display("FAIL disc_first_pc got=%b/%h exp=1/100", instr_valid, instr_pc); end
    endtask

    // Redirect coincident with ack: no discard cycle, word not delivered.
    task automatic test_redirect_ack();
        do_reset();
        repeat (3) tick(0, '0, 1, 1);
        tick(1, 32'h40, 1, 1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            failures++; $display("FAIL rack_addr got=%b/%h exp=1/40", mem_req, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rack_dropped got=%b exp=0", instr_valid); end
        tick(0, '0, 1, 1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || mem_addr !== 32'h44) begin
            failures++; $display("FAIL rack_first got=%b/%h/%h exp=1/40/44", instr_valid, instr_pc, mem_addr); end
    endtask

    // Reset pulse mid-request at 0x20; stale ack must not land in the FIFO.
    task automatic test_reset_mid();
        bit found;
        do_reset();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (mem_req === 1'b1 && mem_addr === 32'h20) found = 1;
            else tick(0, '0, 1, 1);
        end
        checks++; if (!found) begin failures++; $display("FAIL rmid_reach got=timeout exp=addr 20"); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== RESET_PC || instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0) begin
            failures++; $display("FAIL rmid_outputs got=%b/%h/%b/%h/%h exp=0/%h/0/0/0", mem_req, mem_addr, instr_valid, instr, instr_pc, RESET_PC); end
        mem_ack = 1'b1;
        @(negedge clock);
        rst = 1'b1;
        tick(0, '0, 1, 1);
        checks++; if (mem_req !== 1'b1 || mem_addr !== RESET_PC || instr_valid !== 1'b0) begin
            failures++; $display("FAIL rmid_restart got=%b/%h/%b exp=1/%h/0", mem_req, mem_addr, instr_valid, RESET_PC); end
        tick(0, '0, 1, 1);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) begin
            failures++; $display("FAIL rmid_first got=%b/%h exp=1/%h", instr_valid, instr_pc, RESET_PC); end
    endtask

    // Random redirects, ack delays, stray acks and back-pressure vs the model.
    task automatic test_random();
        bit rv, ack, rdy;
        int rdy_pct;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rdy_pct = ((i / 100) % 2 == 0) ? 80 : 25;
            rv  = ($urandom_range(99) < 8);
            rdy = ($urandom_range(99) < rdy_pct);
            ack = m_out ? ($urandom_range(99) < 60) : ($urandom_range(99) < 10);
            tick(rv, $urandom, ack, rdy);
            checks++; if (mem_req !== m_out) begin
                failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", i, mem_req, m_out); end
            if (m_out) begin
                checks++; if (mem_addr !== m_raddr) begin
                    failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", i, mem_addr, m_raddr); end
            end
            checks++; if (instr_valid !== (m_q.size() > 0)) begin
                failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, instr_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                checks++; if ({instr_pc, instr} !== m_q[0]) begin
                    failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h exp=%h/%h", i, instr_pc, instr, m_q[0][63:32], m_q[0][31:0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_stream();
        test_hold();
        test_redirect_discard();
        test_redirect_ack();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
